// File: rtl/imem_boot_arbiter_pkg.sv
// Shared definitions for the instruction-RAM boot arbiter: FSM state encodings and default depth.
package imem_boot_arbiter_pkg;

  localparam int ROM_SIZE_BIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/imem_boot_arbiter_byte_packer.sv
// Packs loader bytes big-endian into 32-bit words; a completed word is presented one cycle later.
module imem_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic [31:0] partial,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [31:0] acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane       <= 2'd0;
      word_ready <= 1'b0;
    end else if (clear) begin
      lane       <= 2'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= byte_valid && (lane == 2'd3);
      if (byte_valid) lane <= lane + 2'd1;
    end
  end

  // The first byte zeroes the low bytes so a flushed partial word has zero padding.
  always_ff @(posedge clk) begin
    if (byte_valid) begin
      case (lane)
        2'd0: acc <= {byte_in, 24'h000000};
        2'd1: acc[23:16] <= byte_in;
        2'd2: acc[15:8] <= byte_in;
        2'd3: word <= {acc[31:8], byte_in};
        default: acc <= acc;
      endcase
    end
  end

  assign partial = acc;

endmodule

// File: rtl/imem_boot_arbiter.sv
// Instruction RAM owner: boots the RAM from a UART byte stream, then serves 1-cycle fetch reads.
// Optional feature macro IMEM_CHECKSUM_EN adds ld_checksum, the sum of all words written since ld_start.
module imem_boot_arbiter
  import imem_boot_arbiter_pkg::*;
#(
  parameter int ROM_SIZE_BIT = ROM_SIZE_BIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_req,
  input  logic [31:0]             fetch_addr,
  output logic [31:0]             fetch_data,
  output logic                    fetch_valid,
  output logic                    fetch_stall,
  input  logic                    ld_start,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_byte_valid,
  input  logic                    ld_done,
  output logic [ROM_SIZE_BIT:0]   ld_words,
  output logic                    ld_overflow,
  output logic                    boot_busy,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ROM_SIZE_BIT-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [31:0]             ld_checksum
`endif
);

  localparam logic [ROM_SIZE_BIT:0] WORDS_MAX = {1'b1, {ROM_SIZE_BIT{1'b0}}};

  state_t                  state_q, state_d;
  logic [ROM_SIZE_BIT-1:0] addr_q;
  logic                    rd_pend_q;
  logic [31:0]             data_hold_q;
  logic                    wr_en, rd_en, pack_valid;
  logic [31:0]             wdata;
  logic [1:0]              lane;
  logic [31:0]             partial, word;
  logic                    word_ready;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{fetch_addr[31:ROM_SIZE_BIT+2], fetch_addr[1:0]};

  assign pack_valid = ld_byte_valid && (state_q == ST_BOOT) && !ld_start;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (ld_start),
    .byte_valid (pack_valid),
    .byte_in    (ld_byte),
    .lane       (lane),
    .partial    (partial),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // ld_start overrides everything, including a pending write or read in the same cycle.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wdata   = word;
    rd_en   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        wr_en = word_ready;
        if (ld_done) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (word_ready) begin
          wr_en = 1'b1;
        end else if (lane != 2'd0) begin
          wr_en = 1'b1;
          wdata = partial;
        end
        state_d = ST_RUN;
      end
      ST_RUN: rd_en = fetch_req;
      default: state_d = ST_BOOT;
    endcase
    if (ld_start) begin
      state_d = ST_BOOT;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
    end
  end

  assign mem_we      = wr_en;
  assign mem_en      = wr_en | rd_en;
  assign mem_addr    = wr_en ? addr_q : fetch_addr[ROM_SIZE_BIT+1:2];
  assign mem_wdata   = wdata;
  assign fetch_stall = (state_q != ST_RUN);
  assign boot_busy   = (state_q != ST_RUN);
  assign fetch_valid = rd_pend_q;
  assign fetch_data  = rd_pend_q ? mem_rdata : data_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      ld_words    <= '0;
      ld_overflow <= 1'b0;
    end else if (ld_start) begin
      addr_q      <= '0;
      ld_words    <= '0;
      ld_overflow <= 1'b0;
    end else if (wr_en) begin
      addr_q <= addr_q + 1'b1;
      if (addr_q == '1) ld_overflow <= 1'b1;
      if (ld_words != WORDS_MAX) ld_words <= ld_words + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      data_hold_q <= 32'h0;
    end else begin
      rd_pend_q <= rd_en;
      if (rd_pend_q) data_hold_q <= mem_rdata;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ld_checksum <= 32'h0;
    else if (ld_start) ld_checksum <= 32'h0;
    else if (wr_en)    ld_checksum <= ld_checksum + wdata;
  end
`endif

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural single-port synchronous RAM.
module tb_imem_boot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        ld_start;
  logic [7:0]  ld_byte;
  logic        ld_byte_valid;
  logic        ld_done;
  logic [8:0]  ld_words;
  logic        ld_overflow;
  logic        boot_busy;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] ld_checksum;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  imem_boot_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .fetch_valid   (fetch_valid),
    .fetch_stall   (fetch_stall),
    .ld_start      (ld_start),
    .ld_byte       (ld_byte),
    .ld_byte_valid (ld_byte_valid),
    .ld_done       (ld_done),
    .ld_words      (ld_words),
    .ld_overflow   (ld_overflow),
    .boot_busy     (boot_busy),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
`ifdef IMEM_CHECKSUM_EN
    ,
    .ld_checksum   (ld_checksum)
`endif
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_byte       = b;
    ld_byte_valid = 1'b1;
    tick();
    ld_byte_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEADBEEF;
    mem_rdata     = 32'h0;
    reset         = 1'b1;
    fetch_req     = 1'b0;
    fetch_addr    = 32'h0;
    ld_start      = 1'b0;
    ld_byte       = 8'h00;
    ld_byte_valid = 1'b0;
    ld_done       = 1'b0;
    tick();
    tick();
    chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
    chk("rst_busy", {31'b0, boot_busy}, 32'd1);
    chk("rst_fvalid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_words", {23'b0, ld_words}, 32'd0);
    chk("rst_ovf", {31'b0, ld_overflow}, 32'd0);
    chk("rst_fdata", fetch_data, 32'h0);
    reset = 1'b0;

    // Case 1: two full words after reset, then ld_done.
    send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("c1_we", {31'b0, mem_we}, 32'd1);
    chk("c1_addr", {24'b0, mem_addr}, 32'd1);
    chk("c1_wdata", mem_wdata, 32'h0);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    chk("c1_words", {23'b0, ld_words}, 32'd2);
    chk("c1_flush_busy", {31'b0, boot_busy}, 32'd1);
    chk("c1_flush_nowe", {31'b0, mem_we}, 32'd0);
    chk("c1_mem0", mem[0], 32'h8C010004);
    chk("c1_mem1", mem[1], 32'h0);
`ifdef IMEM_CHECKSUM_EN
    chk("c1_csum", ld_checksum, 32'h8C010004);
`endif
    tick();
    chk("c1_run_stall", {31'b0, fetch_stall}, 32'd0);
    chk("c1_run_busy", {31'b0, boot_busy}, 32'd0);

    // Case 2: back-to-back fetches.
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    #1;
    chk("c2_en", {31'b0, mem_en}, 32'd1);
    chk("c2_we", {31'b0, mem_we}, 32'd0);
    chk("c2_addr", {24'b0, mem_addr}, 32'd1);
    tick();
    fetch_addr = 32'h0;
    chk("c2_v0", {31'b0, fetch_valid}, 32'd1);
    chk("c2_d0", fetch_data, 32'h0);
    tick();
    fetch_req = 1'b0;
    chk("c2_v1", {31'b0, fetch_valid}, 32'd1);
    chk("c2_d1", fetch_data, 32'h8C010004);
    tick();
    chk("c2_v_idle", {31'b0, fetch_valid}, 32'd0);
    chk("c2_d_hold", fetch_data, 32'h8C010004);

    // Case 3: partial word flushed.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("c3_stall", {31'b0, fetch_stall}, 32'd1);
    chk("c3_words0", {23'b0, ld_words}, 32'd0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    chk("c3_fl_we", {31'b0, mem_we}, 32'd1);
    chk("c3_fl_addr", {24'b0, mem_addr}, 32'd1);
    chk("c3_fl_wdata", mem_wdata, 32'h11220000);
    tick();
    chk("c3_words", {23'b0, ld_words}, 32'd2);
    chk("c3_mem0", mem[0], 32'hAABBCCDD);
    chk("c3_mem1", mem[1], 32'h11220000);
    chk("c3_run", {31'b0, fetch_stall}, 32'd0);

    // Case 4: 257 words wrap the address.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int w = 0; w < 257; w++) begin
      v = 32'h01000000 + 32'(w);
      if (w == 256) begin
        chk("c4_words255", {23'b0, ld_words}, 32'd255);
        chk("c4_ovf_pre", {31'b0, ld_overflow}, 32'd0);
      end
      for (int b = 3; b >= 0; b--) send_byte(v[b*8 +: 8]);
    end
    tick();
    chk("c4_ovf", {31'b0, ld_overflow}, 32'd1);
    chk("c4_words_sat", {23'b0, ld_words}, 32'd256);
    chk("c4_mem0", mem[0], 32'h01000100);
    chk("c4_mem1", mem[1], 32'h01000001);
    chk("c4_mem255", mem[255], 32'h010000FF);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    chk("c4_flush_nowe", {31'b0, mem_we}, 32'd0);
    tick();

    // Case 5: in-flight read dropped, then ld_start beating ld_done.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    ld_start   = 1'b1;
    #1;
    chk("c5_rd_gated", {31'b0, mem_en}, 32'd0);
    tick();
    ld_start = 1'b0;
    chk("c5_drop", {31'b0, fetch_valid}, 32'd0);
    chk("c5_stall", {31'b0, fetch_stall}, 32'd1);
    chk("c5_ovf_clr", {31'b0, ld_overflow}, 32'd0);
    chk("c5_words_clr", {23'b0, ld_words}, 32'd0);
    chk("c5_boot_ignore", {31'b0, mem_en}, 32'd0);
    fetch_req = 1'b0;
    send_byte(8'h12); send_byte(8'h34);
    ld_start = 1'b1;
    ld_done  = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_done  = 1'b0;
    chk("c5_busy", {31'b0, boot_busy}, 32'd1);
    chk("c5_nowe", {31'b0, mem_we}, 32'd0);
    tick();
    chk("c5_noflush", {31'b0, mem_we}, 32'd0);
    chk("c5_stall2", {31'b0, fetch_stall}, 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("c5_lane0_we", {31'b0, mem_we}, 32'd1);
    chk("c5_lane0_addr", {24'b0, mem_addr}, 32'd0);
    chk("c5_lane0_wdata", mem_wdata, 32'h01020304);

    // Case 6: asynchronous reset mid-BOOT.
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    chk("c6_pre_words", {23'b0, ld_words}, 32'd1);
    chk("c6_pre_fdata", fetch_data, 32'h8C010004);
    #2;
    reset = 1'b1;
    #1;
    chk("c6_words", {23'b0, ld_words}, 32'd0);
    chk("c6_mem_en", {31'b0, mem_en}, 32'd0);
    chk("c6_mem_we", {31'b0, mem_we}, 32'd0);
    chk("c6_fdata", fetch_data, 32'h0);
    chk("c6_fvalid", {31'b0, fetch_valid}, 32'd0);
    chk("c6_busy", {31'b0, boot_busy}, 32'd1);
    tick();
    reset = 1'b0;
    send_byte(8'h99);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    chk("c6_fl_we", {31'b0, mem_we}, 32'd1);
    chk("c6_fl_addr", {24'b0, mem_addr}, 32'd0);
    chk("c6_fl_wdata", mem_wdata, 32'h99000000);
    tick();
    chk("c6_run", {31'b0, fetch_stall}, 32'd0);
    chk("c6_mem0", mem[0], 32'h99000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
